// File: rtl/core_pkg.sv
// Shared definitions for the EX->WB stage of the MIPS-subset core:
// multiply opcodes, writeback source select and multiplier state encoding.
package core_pkg;

    localparam logic [3:0] ALU_MULT  = 4'b0110;
    localparam logic [3:0] ALU_MULTU = 4'b0111;

    // Writeback source select; encoding 2'd3 falls back to the ALU result.
    typedef enum logic [1:0] {
        ALU = 2'd0,
        HI  = 2'd1,
        LO  = 2'd2
    } regsel_t;

    // Iterative multiplier sequencing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mstate_t;

    // Only the mult opcode is signed; multu and any other HI/LO opcode are unsigned.
    function automatic logic is_signed_mult(input logic [3:0] op);
        return (op == ALU_MULT);
    endfunction

endpackage

// File: rtl/hilo_wb_stage_if.sv
// EX-side inputs and WB-side outputs of hilo_wb_stage bundled as one bus.
// master = pipeline/control side driving EX, slave = the stage itself.
interface hilo_wb_stage_if #(parameter int WIDTH = 32);

    logic [3:0]       alu_op_EX;
    logic             enhilo_EX;
    logic [1:0]       regsel_EX;
    logic             regwrite_EX;
    logic [4:0]       regdest_EX;
    logic [WIDTH-1:0] alu_result_EX;
    logic [WIDTH-1:0] rs_data_EX;
    logic [WIDTH-1:0] rt_data_EX;
    logic             GPIO_out_en_EX;

    logic             regwrite_WB;
    logic [4:0]       regdest_WB;
    logic [WIDTH-1:0] writedata_WB;
    logic             stall_EX;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] GPIO_OUT;

    modport master (
        output alu_op_EX, enhilo_EX, regsel_EX, regwrite_EX, regdest_EX,
               alu_result_EX, rs_data_EX, rt_data_EX, GPIO_out_en_EX,
        input  regwrite_WB, regdest_WB, writedata_WB, stall_EX, hi, lo, GPIO_OUT
    );

    modport slave (
        input  alu_op_EX, enhilo_EX, regsel_EX, regwrite_EX, regdest_EX,
               alu_result_EX, rs_data_EX, rt_data_EX, GPIO_out_en_EX,
        output regwrite_WB, regdest_WB, writedata_WB, stall_EX, hi, lo, GPIO_OUT
    );

endinterface

// File: rtl/hilo_wb_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, LSB-first on
// the multiplier operand. Signed operands are reduced to magnitudes on start
// and the sign is re-applied to the accumulator when the product is handed out.
// Built only when ITER_MULT_EN is defined.
`ifdef ITER_MULT_EN
module seq_multiplier
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);

    mstate_t            state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;

    // Absolute value for signed operands; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic sg, input logic [WIDTH-1:0] v);
        return (sg && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    // Next-state: operand capture on start, one shift-add step per BUSY cycle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(signed_i, a_i)};
                    mplier_d = magnitude(signed_i, b_i);
                    neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    acc_d    = {(2*WIDTH){1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = BUSY;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + ONE_CNT;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign product_o = neg_q ? (~acc_q + ONE_2W) : acc_q;

endmodule
`endif

// File: rtl/hilo_wb_stage.sv
// EX->WB stage: writeback register, architectural HI/LO, multiply control,
// interlock towards fetch/EX and the GPIO output register.
// Build option ITER_MULT_EN: defined -> 32-step iterative multiplier with a
// HI/LO interlock; undefined -> single-cycle multiply, stall_EX tied low.
module hilo_wb_stage
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    hilo_wb_stage_if.slave bus
);

    logic               regwrite_q, regwrite_d;
    logic [4:0]         regdest_q, regdest_d;
    logic [WIDTH-1:0]   writedata_q, writedata_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   gpio_q, gpio_d;

    regsel_t            sel_s;
    logic               busy_s;
    logic               stall_s;
    logic               accept_s;
    logic               signed_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   wb_src_s;

    assign sel_s    = regsel_t'(bus.regsel_EX);
    assign accept_s = bus.enhilo_EX && !busy_s;
    assign signed_s = is_signed_mult(bus.alu_op_EX);

`ifdef ITER_MULT_EN
    seq_multiplier #(.WIDTH(WIDTH)) u_seq_multiplier (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (accept_s),
        .signed_i  (signed_s),
        .a_i       (bus.rs_data_EX),
        .b_i       (bus.rt_data_EX),
        .busy_o    (busy_s),
        .done_o    (mul_done_s),
        .product_o (prod_s)
    );

    // Anything touching HI/LO waits while a multiply is in flight.
    assign stall_s = busy_s && (bus.enhilo_EX || (sel_s == HI) || (sel_s == LO));
`else
    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;

    // Sign-extend for mult so the truncated 2*WIDTH product is the signed result.
    assign ext_a_s    = {{WIDTH{signed_s & bus.rs_data_EX[WIDTH-1]}}, bus.rs_data_EX};
    assign ext_b_s    = {{WIDTH{signed_s & bus.rt_data_EX[WIDTH-1]}}, bus.rt_data_EX};
    assign prod_s     = ext_a_s * ext_b_s;
    assign busy_s     = 1'b0;
    assign mul_done_s = accept_s;
    assign stall_s    = 1'b0;
`endif

    // Writeback source: HI/LO for mfhi/mflo, ALU result otherwise.
    always_comb begin
        wb_src_s = bus.alu_result_EX;
        case (sel_s)
            HI:      wb_src_s = hi_q;
            LO:      wb_src_s = lo_q;
            ALU:     wb_src_s = bus.alu_result_EX;
            default: wb_src_s = bus.alu_result_EX;
        endcase
    end

    // WB register advances unless stalled, where it emits a bubble and holds data.
    always_comb begin
        regwrite_d  = 1'b0;
        regdest_d   = regdest_q;
        writedata_d = writedata_q;
        if (stall_s) begin
            regwrite_d  = 1'b0;
            regdest_d   = regdest_q;
            writedata_d = writedata_q;
        end else begin
            regwrite_d  = bus.regwrite_EX;
            regdest_d   = bus.regdest_EX;
            writedata_d = wb_src_s;
        end
    end

    // HI/LO take the finished product; GPIO latches rt on an unstalled write.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        gpio_d = gpio_q;
        if (mul_done_s) begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
        if (bus.GPIO_out_en_EX && !stall_s) begin
            gpio_d = bus.rt_data_EX;
        end else begin
            gpio_d = gpio_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            regdest_q   <= 5'd0;
            writedata_q <= {WIDTH{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            gpio_q      <= {WIDTH{1'b0}};
        end else begin
            regwrite_q  <= regwrite_d;
            regdest_q   <= regdest_d;
            writedata_q <= writedata_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            gpio_q      <= gpio_d;
        end
    end

    assign bus.regwrite_WB  = regwrite_q;
    assign bus.regdest_WB   = regdest_q;
    assign bus.writedata_WB = writedata_q;
    assign bus.stall_EX     = stall_s;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.GPIO_OUT     = gpio_q;

endmodule

// File: tb/tb_hilo_wb_stage.sv
// Self-checking bench for hilo_wb_stage. A transaction-level model tracks the
// architectural effect of each EX instruction; the multiply is modelled as an
// arithmetic product that lands in HI/LO after a fixed number of edges.
module tb_hilo_wb_stage;

`ifdef ITER_MULT_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_wb_stage_if #(.WIDTH(32)) ifc ();
    hilo_wb_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        m_wr;
    logic [4:0]  m_dest;
    logic [31:0] m_data, m_hi, m_lo, m_gpio;
    logic [63:0] m_pend;
    int          m_cnt;
    logic        obs_stall, exp_stall;

    function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sg) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic drive(input logic [3:0] op, input logic en, input logic [1:0] sel,
                         input logic wr, input logic [4:0] dest, input logic [31:0] alu,
                         input logic [31:0] rs, input logic [31:0] rt, input logic g);
        ifc.alu_op_EX = op; ifc.enhilo_EX = en; ifc.regsel_EX = sel;
        ifc.regwrite_EX = wr; ifc.regdest_EX = dest; ifc.alu_result_EX = alu;
        ifc.rs_data_EX = rs; ifc.rt_data_EX = rt; ifc.GPIO_out_en_EX = g;
    endtask

    task automatic idle();
        drive(4'h0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // One clock: sample stall mid-cycle, advance the model, wait past the edge.
    task automatic clk_step();
        logic accept;
        logic [63:0] p;
        @(negedge clk);
        obs_stall = ifc.stall_EX;
        exp_stall = (m_cnt != 0) && (ifc.enhilo_EX || ifc.regsel_EX == 2'd1 || ifc.regsel_EX == 2'd2);
        if (rst) begin
            m_wr = 1'b0; m_dest = 5'd0; m_data = 32'h0; m_hi = 32'h0; m_lo = 32'h0;
            m_gpio = 32'h0; m_cnt = 0; m_pend = 64'h0;
        end else begin
            accept = ifc.enhilo_EX && (m_cnt == 0);
            if (!exp_stall) begin
                m_wr   = ifc.regwrite_EX;
                m_dest = ifc.regdest_EX;
                m_data = (ifc.regsel_EX == 2'd1) ? m_hi :
                         (ifc.regsel_EX == 2'd2) ? m_lo : ifc.alu_result_EX;
                if (ifc.GPIO_out_en_EX) m_gpio = ifc.rt_data_EX;
            end else begin
                m_wr = 1'b0;
            end
            if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) {m_hi, m_lo} = m_pend;
            end else if (accept) begin
                p = ref_mul(ifc.alu_op_EX == 4'b0110, ifc.rs_data_EX, ifc.rt_data_EX);
                if (MUL_LAT == 0) {m_hi, m_lo} = p;
                else begin m_pend = p; m_cnt = MUL_LAT; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && m_cnt != 0; k++) clk_step();
        total++; if (m_cnt != 0) begin bad++; $display("FAIL wait_idle: model still busy cnt=%0d required 0", m_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0111, 1'b1, 2'd1, 1'b1, 5'd31, 32'hDEAD, 32'h5, 32'h7, 1'b1);
        clk_step();
        clk_step();
        rst = 1'b0;
        idle();
        total++; if (ifc.regwrite_WB !== 1'b0) begin bad++; $display("FAIL reset_regwrite: got %0b want 0", ifc.regwrite_WB); end
        total++; if (ifc.regdest_WB !== 5'd0) begin bad++; $display("FAIL reset_regdest: got %0d want 0", ifc.regdest_WB); end
        total++; if (ifc.writedata_WB !== 32'h0) begin bad++; $display("FAIL reset_writedata: got %h want 0", ifc.writedata_WB); end
        total++; if (ifc.hi !== 32'h0 || ifc.lo !== 32'h0) begin bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", ifc.hi, ifc.lo); end
        total++; if (ifc.GPIO_OUT !== 32'h0) begin bad++; $display("FAIL reset_gpio: got %h want 0", ifc.GPIO_OUT); end
        ifc.regsel_EX = 2'd1;
        clk_step();
        total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", obs_stall); end
        idle();
    endtask

    task automatic test_multu_max();
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi; old_lo = m_lo;
        drive(4'b0111, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        clk_step();
        idle();
        for (int i = 0; i < MUL_LAT; i++) begin
            total++; if (ifc.hi !== old_hi || ifc.lo !== old_lo) begin bad++; $display("FAIL multu_early: step %0d got %h/%h want %h/%h", i, ifc.hi, ifc.lo, old_hi, old_lo); end
            clk_step();
        end
        total++; if (ifc.hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", ifc.hi); end
        total++; if (ifc.lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", ifc.lo); end
    endtask

    task automatic test_mult_neg();
        drive(4'b0110, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFD, 32'h5, 1'b0);
        clk_step();
        idle();
        for (int i = 0; i < MUL_LAT; i++) clk_step();
        total++; if (ifc.hi !== 32'hFFFFFFFF || ifc.lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_neg: got %h/%h want ffffffff/fffffff1", ifc.hi, ifc.lo); end
    endtask

    task automatic test_mfhi_dependent();
        int stalled;
        stalled = 0;
        drive(4'b0110, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 32'd7, 32'd6, 1'b0);
        clk_step();
        drive(4'h0, 1'b0, 2'd1, 1'b1, 5'd8, 32'hCAFE, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            clk_step();
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL mfhi_stall: cycle %0d got %0b want %0b", k, obs_stall, exp_stall); end
            if (!obs_stall) break;
            stalled++;
            total++; if (ifc.regwrite_WB !== 1'b0) begin bad++; $display("FAIL mfhi_bubble: cycle %0d got %0b want 0", k, ifc.regwrite_WB); end
        end
        total++; if (stalled != MUL_LAT) begin bad++; $display("FAIL mfhi_stall_len: got %0d want %0d", stalled, MUL_LAT); end
        total++; if (ifc.regwrite_WB !== 1'b1 || ifc.regdest_WB !== 5'd8) begin bad++; $display("FAIL mfhi_wb: got wr=%0b dest=%0d want 1/8", ifc.regwrite_WB, ifc.regdest_WB); end
        total++; if (ifc.writedata_WB !== 32'h0) begin bad++; $display("FAIL mfhi_data: got %h want 0", ifc.writedata_WB); end
        drive(4'h0, 1'b0, 2'd2, 1'b1, 5'd9, 32'hCAFE, 32'h0, 32'h0, 1'b0);
        clk_step();
        total++; if (ifc.writedata_WB !== 32'h2A || ifc.regdest_WB !== 5'd9) begin bad++; $display("FAIL mflo_data: got %h dest %0d want 2a/9", ifc.writedata_WB, ifc.regdest_WB); end
        idle();
    endtask

    task automatic test_alu_during_busy();
        drive(4'b0111, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 32'h00010000, 32'h00010003, 1'b0);
        clk_step();
        drive(4'h2, 1'b0, 2'd0, 1'b1, 5'd3, 32'h1234, 32'h0, 32'h0, 1'b0);
        clk_step();
        total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL add_stall: got %0b want 0", obs_stall); end
        total++; if (ifc.writedata_WB !== 32'h1234 || ifc.regwrite_WB !== 1'b1) begin bad++; $display("FAIL add_wb: got %h wr=%0b want 1234/1", ifc.writedata_WB, ifc.regwrite_WB); end
        idle();
        wait_idle();
        total++; if (ifc.hi !== 32'h1 || ifc.lo !== 32'h00030000) begin bad++; $display("FAIL add_mult_result: got %h/%h want 1/30000", ifc.hi, ifc.lo); end
    endtask

    task automatic test_reset_mid_multiply();
        drive(4'b0111, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 32'h12345, 32'h6789A, 1'b0);
        clk_step();
        idle();
        for (int i = 1; i < 10; i++) clk_step();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        total++; if (ifc.hi !== 32'h0 || ifc.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", ifc.hi, ifc.lo); end
        ifc.regsel_EX = 2'd1;
        clk_step();
        total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %0b want 0", obs_stall); end
        total++; if (ifc.hi !== 32'h0 || ifc.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_nowrite: got %h/%h want 0/0", ifc.hi, ifc.lo); end
        drive(4'b0111, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 32'd3, 32'd4, 1'b0);
        clk_step();
        idle();
        for (int i = 0; i < MUL_LAT; i++) clk_step();
        total++; if (ifc.lo !== 32'd12 || ifc.hi !== 32'd0) begin bad++; $display("FAIL rst_mid_new: got %h/%h want 0/c", ifc.hi, ifc.lo); end
    endtask

    task automatic test_gpio();
        for (int i = 0; i < 6; i++) begin
            drive(4'h0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0, $urandom, 1'b1);
            clk_step();
            total++; if (ifc.GPIO_OUT !== m_gpio) begin bad++; $display("FAIL gpio: got %h want %h", ifc.GPIO_OUT, m_gpio); end
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 3) == 0) ? 4'b0110 : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom), $urandom,
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom,
                  ($urandom_range(0, 1) == 0) ? -32'($urandom_range(0, 300)) : $urandom,
                  ($urandom_range(0, 3) == 0));
            clk_step();
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall: cyc %0d got %0b want %0b", i, obs_stall, exp_stall); end
            total++; if (ifc.regwrite_WB !== m_wr) begin bad++; $display("FAIL rnd_regwrite: cyc %0d got %0b want %0b", i, ifc.regwrite_WB, m_wr); end
            total++; if (ifc.regdest_WB !== m_dest) begin bad++; $display("FAIL rnd_regdest: cyc %0d got %0d want %0d", i, ifc.regdest_WB, m_dest); end
            total++; if (ifc.writedata_WB !== m_data) begin bad++; $display("FAIL rnd_data: cyc %0d got %h want %h", i, ifc.writedata_WB, m_data); end
            total++; if (ifc.hi !== m_hi || ifc.lo !== m_lo) begin bad++; $display("FAIL rnd_hilo: cyc %0d got %h/%h want %h/%h", i, ifc.hi, ifc.lo, m_hi, m_lo); end
            total++; if (ifc.GPIO_OUT !== m_gpio) begin bad++; $display("FAIL rnd_gpio: cyc %0d got %h want %h", i, ifc.GPIO_OUT, m_gpio); end
        end
        rst = 1'b0;
        idle();
        wait_idle();
    endtask

    initial begin
        m_wr = 1'b0; m_dest = 5'd0; m_data = 32'h0; m_hi = 32'h0; m_lo = 32'h0;
        m_gpio = 32'h0; m_cnt = 0; m_pend = 64'h0;
        idle();
        test_reset();
        test_multu_max();
        test_mult_neg();
        test_mfhi_dependent();
        test_alu_during_busy();
        test_reset_mid_multiply();
        test_gpio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
